// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into RV32I machine words over valid/ready streams.
// LI expands to ADDI, or LUI plus an optional ADDI held in a pending register.
module instr_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [3:0]         kind_i,
    input  logic [4:0]         rd_i,
    input  logic [4:0]         rs1_i,
    input  logic [4:0]         rs2_i,
    input  logic [2:0]         funct3_i,
    input  logic [6:0]         funct7_i,
    input  logic [31:0]        imm_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        instr_o,
    output logic               illegal_o,
    output logic [COUNT_W-1:0] count_o
);

    // state  | meaning
    // S_IDLE | output register empty or holding a single word
    // S_PEND | second LI word waiting in r_pend
    typedef enum logic {S_IDLE, S_PEND} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_instr;
    logic [31:0]          r_pend;
    logic                 r_out_valid;
    logic                 r_illegal;
    logic [COUNT_W-1:0]   r_count;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_hs;
    logic [31:0]          w_word0;
    logic [31:0]          w_word1;
    logic                 w_two;
    logic                 w_legal;
    logic                 w_li_fits;
    logic [19:0]          w_li_hi;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready_i);
    assign w_accept   = in_valid_i && w_in_ready;
    assign w_hs       = r_out_valid && out_ready_i;

    // Rounding up by imm[11] compensates for the ADDI sign-extending its low 12 bits.
    assign w_li_fits = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign w_li_hi   = imm_i[31:12] + {19'd0, imm_i[11]};

    always_comb begin
        w_word0 = '0;
        w_word1 = '0;
        w_two   = 1'b0;
        w_legal = 1'b1;
        case (kind_i)
            4'd0: w_word0 = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            4'd1: begin
                if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    w_word0 = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I};
                else
                    w_word0 = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
            end
            4'd2: w_word0 = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
            4'd3: w_word0 = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
            4'd4: w_word0 = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], OP_BRANCH};
            4'd5: w_word0 = {imm_i[31:12], rd_i, OP_LUI};
            4'd6: w_word0 = {imm_i[31:12], rd_i, OP_AUIPC};
            4'd7: w_word0 = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
            4'd8: w_word0 = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
            4'd9: begin
                if (w_li_fits) begin
                    w_word0 = {imm_i[11:0], 5'd0, 3'b000, rd_i, OP_I};
                end else begin
                    w_word0 = {w_li_hi, rd_i, OP_LUI};
                    w_word1 = {imm_i[11:0], rd_i, 3'b000, rd_i, OP_I};
                    w_two   = |imm_i[11:0];
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_legal && w_two) w_state_nxt = S_PEND;
            S_PEND: if (w_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instr     <= '0;
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (w_hs) r_count <= r_count + 1'b1;
            if (w_accept && w_legal) begin
                r_instr     <= w_word0;
                r_out_valid <= 1'b1;
                if (w_two) r_pend <= w_word1;
            end else if (w_hs) begin
                if (r_state == S_PEND) r_instr <= r_pend;
                else r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign instr_o     = r_instr;
    assign illegal_o   = r_illegal;
    assign count_o     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, stalls, LI expansion, illegal kind, reset in S_PEND.
module tb_instr_encoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  kind_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic        illegal_o;
    logic [15:0] count_o;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    instr_encoder #(.COUNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .kind_i(kind_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .instr_o(instr_o), .illegal_o(illegal_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_valid_i = 1'b1;
        kind_i = k; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
    endtask

    initial begin
        vecs[0] = '{4'd1, 5'd1, 5'd2, 5'd0, 3'b101, 7'h20, 32'd3,  32'h40315093}; // SRAI x1,x2,3
        vecs[1] = '{4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'd8,  32'h0020A423}; // SW x2,8(x1)
        vecs[2] = '{4'd2, 5'd3, 5'd1, 5'd0, 3'b010, 7'h00, 32'd4,  32'h0040A183}; // LW x3,4(x1)
        vecs[3] = '{4'd6, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h12345000, 32'h12345097}; // AUIPC
        vecs[4] = '{4'd8, 5'd1, 5'd2, 5'd0, 3'b111, 7'h00, 32'd4,  32'h004100E7}; // JALR f3 forced 0
        vecs[5] = '{4'd1, 5'd1, 5'd2, 5'd0, 3'b000, 7'h00, 32'd5,  32'h00510093}; // ADDI x1,x2,5

        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid_i = 1'b0;
        #12;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        @(negedge clk_i); rst_ni = 1'b1;
        cyc();

        // LI x5, 0x12345678 -> LUI then ADDI
        out_ready_i = 1'b1;
        drive(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        #1 chk("li_in_ready", in_ready_o, 1);
        cyc(); in_valid_i = 1'b0; #1;
        chk("li_lui", instr_o, 32'h123452B7);
        chk("li_valid0", out_valid_o, 1);
        chk("li_pend_ready", in_ready_o, 0);
        chk("li_cnt0", count_o, exp_cnt);
        cyc(); exp_cnt++;
        chk("li_addi", instr_o, 32'h67828293);
        chk("li_valid1", out_valid_o, 1);
        chk("li_ready_back", in_ready_o, 1);
        chk("li_cnt1", count_o, exp_cnt);
        cyc(); exp_cnt++;
        chk("li_drain", out_valid_o, 0);
        chk("li_cnt2", count_o, exp_cnt);

        // LI boundaries, back-to-back
        drive(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        cyc();
        chk("li_neg", instr_o, 32'h80000293);
        drive(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
        #1 chk("li_neg_ready", in_ready_o, 1);
        cyc(); exp_cnt++; in_valid_i = 1'b0; #1;
        chk("li800_lui", instr_o, 32'h000012B7);
        chk("li800_cnt", count_o, exp_cnt);
        cyc(); exp_cnt++;
        chk("li800_addi", instr_o, 32'h80028293);
        cyc(); exp_cnt++;
        chk("li800_drain", out_valid_o, 0);
        drive(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
        cyc(); in_valid_i = 1'b0; #1;
        chk("li1000_lui", instr_o, 32'h000012B7);
        chk("li1000_single_ready", in_ready_o, 1);
        cyc(); exp_cnt++;
        chk("li1000_only", out_valid_o, 0);
        chk("li1000_cnt", count_o, exp_cnt);

        // Stall: BRANCH held, JAL waits, then SUB back-to-back
        out_ready_i = 1'b0;
        drive(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        cyc();
        drive(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        #1;
        chk("br_word", instr_o, 32'h00208463);
        chk("br_stall_ready", in_ready_o, 0);
        cyc();
        chk("br_hold1", instr_o, 32'h00208463);
        chk("br_hold_cnt", count_o, exp_cnt);
        cyc();
        chk("br_hold2", instr_o, 32'h00208463);
        out_ready_i = 1'b1;
        #1 chk("br_release_ready", in_ready_o, 1);
        cyc(); exp_cnt++;
        chk("jal_word", instr_o, 32'h008000EF);
        chk("jal_cnt", count_o, exp_cnt);
        drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        cyc(); exp_cnt++; in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
        chk("sub_word", instr_o, 32'h402081B3);
        cyc();
        chk("sub_hold", instr_o, 32'h402081B3);
        chk("sub_hold_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        cyc(); exp_cnt++;
        chk("sub_drain", out_valid_o, 0);
        chk("sub_cnt", count_o, exp_cnt);

        // LI with stall while pending
        out_ready_i = 1'b0;
        drive(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        cyc(); in_valid_i = 1'b0;
        cyc();
        chk("lis_hold_lui", instr_o, 32'h123452B7);
        chk("lis_pend_ready", in_ready_o, 0);
        out_ready_i = 1'b1;
        cyc(); exp_cnt++;
        chk("lis_addi", instr_o, 32'h67828293);
        cyc(); exp_cnt++;
        chk("lis_cnt", count_o, exp_cnt);

        // Table of remaining formats, back-to-back at full rate
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].f3, vecs[i].f7, vecs[i].imm);
            cyc();
            if (i > 0) exp_cnt++;
            chk($sformatf("tbl_word%0d", i), instr_o, vecs[i].exp);
            chk($sformatf("tbl_cnt%0d", i), count_o, exp_cnt);
        end
        in_valid_i = 1'b0;
        cyc(); exp_cnt++;
        chk("tbl_drain", out_valid_o, 0);

        // Illegal kind alone
        drive(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        #1 chk("ill_ready", in_ready_o, 1);
        cyc(); in_valid_i = 1'b0; #1;
        chk("ill_pulse", illegal_o, 1);
        chk("ill_no_valid", out_valid_o, 0);
        chk("ill_cnt", count_o, exp_cnt);
        cyc();
        chk("ill_pulse_end", illegal_o, 0);
        chk("ill_no_valid2", out_valid_o, 0);

        // Illegal accepted while an older word completes its handshake
        out_ready_i = 1'b0;
        drive(4'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        cyc();
        drive(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        out_ready_i = 1'b1;
        cyc(); exp_cnt++; in_valid_i = 1'b0; #1;
        chk("illhs_pulse", illegal_o, 1);
        chk("illhs_valid", out_valid_o, 0);
        chk("illhs_cnt", count_o, exp_cnt);

        // Reset while pending drops the ADDI
        out_ready_i = 1'b0;
        drive(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
        cyc(); in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rstp_valid", out_valid_o, 0);
        chk("rstp_count", count_o, 0);
        chk("rstp_instr", instr_o, 0);
        chk("rstp_idle", in_ready_o, 1);
        @(negedge clk_i); rst_ni = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("rstp_no_addi%0d", i), out_valid_o, 0);
        end
        chk("rstp_count_after", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
